// File: rtl/ethernet_mdio_responder_pkg.sv
// rtl/ethernet_mdio_responder_pkg.sv - shared opcodes, register indices and frame FSM encoding
package ethernet_mdio_responder_pkg;

    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] OP_WRITE = 2'b01;

    localparam logic [4:0] REG_CTRL   = 5'd0;
    localparam logic [4:0] REG_STATUS = 5'd1;
    localparam logic [4:0] REG_ID1    = 5'd2;
    localparam logic [4:0] REG_ID2    = 5'd3;

    localparam logic [5:0] PREAMBLE_LEN = 6'd32;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ST    = 3'd1,
        ST_OP    = 3'd2,
        ST_PHYAD = 3'd3,
        ST_REGAD = 3'd4,
        ST_TA    = 3'd5,
        ST_DATA  = 3'd6
    } mdio_state_t;

    // Bit-counter value of the last bit of each frame field
    function automatic logic [4:0] field_last(input mdio_state_t s);
        case (s)
            ST_OP, ST_TA:       field_last = 5'd1;
            ST_PHYAD, ST_REGAD: field_last = 5'd4;
            ST_DATA:            field_last = 5'd15;
            default:            field_last = 5'd0;
        endcase
    endfunction

endpackage

// File: rtl/ethernet_mdio_responder_edge_sync.sv
// rtl/ethernet_mdio_responder_edge_sync.sv - MDC/MDIO synchroniser with registered MDC rise/fall pulses
module ethernet_mdio_responder_edge_sync (
    input  logic clk,
    input  logic resetn,
    input  logic mdc,
    input  logic mdio,
    output logic mdc_rise,
    output logic mdc_fall,
    output logic mdio_sync
);

    logic [2:0] mdc_q;
    logic [1:0] mdio_q;

    // mdio_sync is delayed one stage so it lines up with the edge pulses
    always_ff @(posedge clk) begin
        if (!resetn) begin
            mdc_q     <= 3'b000;
            mdio_q    <= 2'b00;
            mdc_rise  <= 1'b0;
            mdc_fall  <= 1'b0;
            mdio_sync <= 1'b0;
        end else begin
            mdc_q     <= {mdc_q[1:0], mdc};
            mdio_q    <= {mdio_q[0], mdio};
            mdc_rise  <= mdc_q[1] & ~mdc_q[2];
            mdc_fall  <= ~mdc_q[1] & mdc_q[2];
            mdio_sync <= mdio_q[1];
        end
    end

endmodule

// File: rtl/ethernet_mdio_responder.sv
// rtl/ethernet_mdio_responder.sv - Clause-22 MDIO PHY-side responder with a small register file
// Optional MDIO_PREAMBLE_SUPPRESS_EN: after a valid frame to this PHY, one idle 1 bit suffices as preamble.
module ethernet_mdio_responder #(
    parameter logic [4:0]  PHY_ADDR   = 5'd7,
    parameter int          NUM_REGS   = 8,
    parameter logic [15:0] CTRL_RESET = 16'h1140,
    parameter logic [15:0] PHY_ID1    = 16'h0141,
    parameter logic [15:0] PHY_ID2    = 16'h0CC2
) (
    input  logic        clk_eth_i,
    input  logic        rst_eth_n_i,
    input  logic        mdio_mdc_i,
    input  logic        mdio_mdio_i,
    output logic        mdio_mdio_o,
    output logic        mdio_mdio_t,
    input  logic [15:0] status_i,
    output logic [15:0] ctrl_o,
    output logic        soft_reset_o,
    output logic        wr_strobe_o,
    output logic [4:0]  wr_addr_o,
    output logic [15:0] wr_data_o
);

    import ethernet_mdio_responder_pkg::*;

    logic        mdc_rise;
    logic        mdc_fall;
    logic        mdio_in;

    mdio_state_t state_q;
    mdio_state_t state_d;
    logic [4:0]  bit_cnt;
    logic        field_done;
    logic [5:0]  pre_cnt;
    logic [5:0]  pre_sat;
    logic [5:0]  pre_one;
    logic        op_msb;
    logic        is_read;
    logic        addr_match;
    logic [3:0]  phy_sh;
    logic [3:0]  reg_sh;
    logic [4:0]  regad_q;
    logic [4:0]  regad_now;
    logic [14:0] wr_sh;
    logic [15:0] wr_word;
    logic [15:0] rd_word;
    logic [15:0] rd_sh;
    logic        rd_active;
    logic [4:0]  drv_cnt;
    logic [15:0] regs [NUM_REGS];

    ethernet_mdio_responder_edge_sync u_edge_sync (
        .clk       (clk_eth_i),
        .resetn    (rst_eth_n_i),
        .mdc       (mdio_mdc_i),
        .mdio      (mdio_mdio_i),
        .mdc_rise  (mdc_rise),
        .mdc_fall  (mdc_fall),
        .mdio_sync (mdio_in)
    );

    assign field_done = (bit_cnt == field_last(state_q));
    assign regad_now  = {reg_sh, mdio_in};
    assign wr_word    = {wr_sh, mdio_in};
    assign pre_sat    = (pre_cnt == PREAMBLE_LEN) ? pre_cnt : pre_cnt + 6'd1;

`ifdef MDIO_PREAMBLE_SUPPRESS_EN
    logic supp_arm;

    // Armed by a complete frame to this PHY; the first idle 1 then counts as a full preamble
    always_ff @(posedge clk_eth_i) begin
        if (!rst_eth_n_i) begin
            supp_arm <= 1'b0;
        end else if (mdc_rise) begin
            if (state_q == ST_DATA && field_done) begin
                supp_arm <= addr_match;
            end else if (state_q == ST_IDLE) begin
                supp_arm <= 1'b0;
            end
        end
    end

    assign pre_one = supp_arm ? PREAMBLE_LEN : pre_sat;
`else
    assign pre_one = pre_sat;
`endif

    always_ff @(posedge clk_eth_i) begin
        if (!rst_eth_n_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (mdc_rise) begin
            case (state_q)
                ST_IDLE: begin
                    if (!mdio_in && pre_cnt == PREAMBLE_LEN) state_d = ST_ST;
                end
                ST_ST: begin
                    state_d = mdio_in ? ST_OP : ST_IDLE;
                end
                ST_OP: begin
                    if (field_done) begin
                        if ({op_msb, mdio_in} == OP_READ || {op_msb, mdio_in} == OP_WRITE) begin
                            state_d = ST_PHYAD;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                ST_PHYAD: if (field_done) state_d = ST_REGAD;
                ST_REGAD: if (field_done) state_d = ST_TA;
                ST_TA:    if (field_done) state_d = ST_DATA;
                ST_DATA:  if (field_done) state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // Read data source, evaluated at the last REGAD bit so status_i is captured then
    always_comb begin
        rd_word = 16'h0000;
        case (regad_now)
            REG_CTRL:   rd_word = ctrl_o;
            REG_STATUS: rd_word = status_i;
            REG_ID1:    rd_word = PHY_ID1;
            REG_ID2:    rd_word = PHY_ID2;
            default: begin
                for (int i = 4; i < NUM_REGS; i++) begin
                    if (regad_now == 5'(i)) rd_word = regs[i];
                end
            end
        endcase
    end

    always_ff @(posedge clk_eth_i) begin
        if (!rst_eth_n_i) begin
            bit_cnt      <= 5'd0;
            pre_cnt      <= 6'd0;
            op_msb       <= 1'b0;
            is_read      <= 1'b0;
            addr_match   <= 1'b0;
            phy_sh       <= 4'd0;
            reg_sh       <= 4'd0;
            regad_q      <= 5'd0;
            wr_sh        <= 15'd0;
            rd_sh        <= 16'd0;
            rd_active    <= 1'b0;
            drv_cnt      <= 5'd0;
            mdio_mdio_o  <= 1'b0;
            mdio_mdio_t  <= 1'b1;
            ctrl_o       <= CTRL_RESET;
            soft_reset_o <= 1'b0;
            wr_strobe_o  <= 1'b0;
            wr_addr_o    <= 5'd0;
            wr_data_o    <= 16'd0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= 16'd0;
            end
        end else begin
            wr_strobe_o  <= 1'b0;
            soft_reset_o <= 1'b0;

            if (mdc_rise) begin
                bit_cnt <= (state_d == state_q) ? bit_cnt + 5'd1 : 5'd0;
                case (state_q)
                    ST_IDLE: begin
                        pre_cnt <= mdio_in ? pre_one : 6'd0;
                    end
                    ST_OP: begin
                        op_msb <= mdio_in;
                        if (field_done) is_read <= ({op_msb, mdio_in} == OP_READ);
                    end
                    ST_PHYAD: begin
                        phy_sh <= {phy_sh[2:0], mdio_in};
                        if (field_done) addr_match <= ({phy_sh, mdio_in} == PHY_ADDR);
                    end
                    ST_REGAD: begin
                        reg_sh <= {reg_sh[2:0], mdio_in};
                        if (field_done) begin
                            regad_q <= regad_now;
                            if (is_read && addr_match) begin
                                rd_sh     <= rd_word;
                                rd_active <= 1'b1;
                                drv_cnt   <= 5'd0;
                            end
                        end
                    end
                    ST_DATA: begin
                        wr_sh <= {wr_sh[13:0], mdio_in};
                        if (field_done) begin
                            pre_cnt <= 6'd0;
                            if (!is_read && addr_match) begin
                                wr_strobe_o <= 1'b1;
                                wr_addr_o   <= regad_q;
                                wr_data_o   <= wr_word;
                                if (regad_q == REG_CTRL) begin
                                    if (wr_word[15]) begin
                                        ctrl_o       <= CTRL_RESET;
                                        soft_reset_o <= 1'b1;
                                    end else begin
                                        ctrl_o <= wr_word;
                                    end
                                end
                                for (int i = 4; i < NUM_REGS; i++) begin
                                    if (regad_q == 5'(i)) regs[i] <= wr_word;
                                end
                            end
                        end
                    end
                    default: ;
                endcase
            end

            // Read turnaround and data: fall 0 stays released, fall 1 drives 0, falls 2..17 data, fall 18 releases
            if (mdc_fall && rd_active) begin
                drv_cnt <= drv_cnt + 5'd1;
                if (drv_cnt == 5'd0) begin
                    mdio_mdio_t <= 1'b1;
                    mdio_mdio_o <= 1'b0;
                end else if (drv_cnt == 5'd1) begin
                    mdio_mdio_t <= 1'b0;
                    mdio_mdio_o <= 1'b0;
                end else if (drv_cnt <= 5'd17) begin
                    mdio_mdio_t <= 1'b0;
                    mdio_mdio_o <= rd_sh[15];
                    rd_sh       <= {rd_sh[14:0], 1'b0};
                end else begin
                    mdio_mdio_t <= 1'b1;
                    mdio_mdio_o <= 1'b0;
                    rd_active   <= 1'b0;
                end
            end
        end
    end

endmodule
